// File: rtl/systolic_drain.sv
// systolic_drain: realigns time-skewed column results from the systolic array into full rows
// and buffers them in a FWFT FIFO with tile framing, optional ReLU and a sticky drop flag.
module systolic_drain #(
    parameter int sys_cols   = 2,
    parameter int P_BITWIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS_W     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   col_valid_in,
    input  logic [sys_cols-1:0][P_BITWIDTH-1:0]    of_data,
    input  logic [ROWS_W-1:0]                      tile_rows,
    input  logic                                   relu_en,
    input  logic                                   clear,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [sys_cols-1:0][P_BITWIDTH-1:0]    out_data,
    output logic                                   out_last,
    output logic                                   overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [sys_cols-2:0]                   vsh;
    logic [sys_cols-1:0]                   tap;
    logic [sys_cols-1:0][P_BITWIDTH-1:0]   aligned;
    logic [sys_cols-1:0][P_BITWIDTH-1:0]   mem [FIFO_DEPTH];
    logic [sys_cols-1:0][P_BITWIDTH-1:0]   head;
    logic [FIFO_DEPTH-1:0]                 lst;
    logic [AW:0]                           wp, rp;
    logic [ROWS_W-1:0]                     cnt, trl, tr_eff;
    logic                                  push, pop, wr, full, empty, last_now;

    // tap[c] is high in the cycle column c of a row is present on of_data
    assign tap = {vsh, col_valid_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vsh <= '0;
        else vsh <= clear ? '0 : tap[sys_cols-2:0];
    end

    for (genvar c = 0; c < sys_cols - 1; c++) begin : g_col
        localparam int N = sys_cols - 1 - c;
        logic [P_BITWIDTH-1:0] dl [N];
        // each stage advances only when the row reaches the matching column tap
        always_ff @(posedge clk or posedge rst) begin
            if (rst || clear) begin
                for (int k = 0; k < N; k++) dl[k] <= '0;
            end else begin
                if (tap[c]) dl[0] <= of_data[c];
                for (int k = 1; k < N; k++) if (tap[c+k]) dl[k] <= dl[k-1];
            end
        end
        assign aligned[c] = dl[N-1];
    end
    assign aligned[sys_cols-1] = of_data[sys_cols-1];

    always_comb begin
        push      = tap[sys_cols-1];
        empty     = wp == rp;
        full      = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
        pop       = !empty && out_ready;
        wr        = push && (!full || pop);
        tr_eff    = cnt == '0 ? tile_rows : trl;
        last_now  = cnt == tr_eff;
        head      = mem[rp[AW-1:0]];
        out_valid = !empty;
        out_last  = !empty && lst[rp[AW-1:0]];
        out_data  = head;
        for (int i = 0; i < sys_cols; i++)
            out_data[i] = relu_en && head[i][P_BITWIDTH-1] ? '0 : head[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            trl      <= '0;
            overflow <= 1'b0;
            lst      <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
        end else if (clear) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) rp <= rp + (AW+1)'(1);
            if (wr) begin
                mem[wp[AW-1:0]] <= aligned;
                lst[wp[AW-1:0]] <= last_now;
                wp              <= wp + (AW+1)'(1);
            end
            if (push && !wr) overflow <= 1'b1;
            // the counter advances even for dropped rows so tile framing survives a loss
            if (push) begin
                if (cnt == '0) trl <= tile_rows;
                cnt <= last_now ? '0 : cnt + ROWS_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed and random stimulus for systolic_drain, checked against a
// row-level queue model of the realigned FIFO output.
module tb_systolic_drain;
    localparam int SC = 2;
    localparam int PW = 32;
    localparam int D  = 4;
    localparam int RW = 8;

    typedef logic [SC-1:0][PW-1:0] row_t;

    logic clk, rst, col_valid_in, relu_en, clear, out_valid, out_ready, out_last, overflow;
    logic [SC-1:0][PW-1:0] of_data, out_data;
    logic [RW-1:0] tile_rows;

    systolic_drain #(.sys_cols(SC), .P_BITWIDTH(PW), .FIFO_DEPTH(D), .ROWS_W(RW)) dut (
        .clk(clk), .rst(rst), .col_valid_in(col_valid_in), .of_data(of_data),
        .tile_rows(tile_rows), .relu_en(relu_en), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    row_t q_d[$];
    bit   q_l[$];
    bit   m_ovf;
    int   m_cnt, m_trl, cyc, errs, checks;
    bit   inj_v [0:4095];
    row_t inj_d [0:4095];
    row_t z = '0;

    function automatic row_t mk(input int a, input int b);
        row_t r;
        r[0] = PW'(a);
        r[1] = PW'(b);
        return r;
    endfunction

    function automatic row_t relu(input row_t r);
        row_t o = r;
        for (int i = 0; i < SC; i++) if (relu_en && r[i][PW-1]) o[i] = '0;
        return o;
    endfunction

    task automatic check(input string tag, input logic [SC*PW-1:0] obs, input logic [SC*PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // one clock cycle: drive skewed lanes, check outputs, then advance the row-level model
    task automatic cycle(input bit v, input row_t d, input bit rdy, input bit clr);
        bit pop, l;
        inj_v[cyc] = v;
        inj_d[cyc] = d;
        col_valid_in = v;
        out_ready = rdy;
        clear = clr;
        for (int c = 0; c < SC; c++)
            of_data[c] = (cyc >= c && inj_v[cyc-c]) ? inj_d[cyc-c][c] : PW'($urandom);
        @(negedge clk);
        check("out_valid", out_valid, q_d.size() > 0);
        if (q_d.size() > 0) begin
            check("out_data", out_data, relu(q_d[0]));
            check("out_last", out_last, q_l[0]);
        end
        check("overflow", overflow, m_ovf);
        pop = q_d.size() > 0 && rdy;
        if (clr) begin
            q_d.delete();
            q_l.delete();
            m_ovf = 0;
            m_cnt = 0;
            for (int k = 0; k < SC; k++) if (cyc >= k) inj_v[cyc-k] = 0;
        end else begin
            if (pop) begin
                void'(q_d.pop_front());
                void'(q_l.pop_front());
            end
            if (cyc >= SC - 1 && inj_v[cyc-SC+1]) begin
                if (m_cnt == 0) m_trl = int'(tile_rows);
                l = m_cnt == m_trl;
                m_cnt = l ? 0 : m_cnt + 1;
                if (q_d.size() < D) begin
                    q_d.push_back(inj_d[cyc-SC+1]);
                    q_l.push_back(l);
                end else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        col_valid_in = 1'b0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_last", out_last, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        q_d.delete();
        q_l.delete();
        m_ovf = 0;
        m_cnt = 0;
        for (int k = 0; k <= cyc; k++) inj_v[k] = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc++;
    endtask

    initial begin
        rst = 1'b0; col_valid_in = 1'b0; of_data = '0; tile_rows = 8'd3;
        relu_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
        cyc = 0; errs = 0; checks = 0; m_cnt = 0; m_trl = 0; m_ovf = 0;
        do_reset();
        // single row
        cycle(1, mk(5, 7), 0, 0);
        cycle(0, z, 0, 0);
        check("single_data", out_data, mk(5, 7));
        cycle(0, z, 1, 0);
        cycle(0, z, 0, 0);
        // streaming 8 rows
        for (int i = 0; i < 8; i++) cycle(1, mk(i, 100 + i), 1, 0);
        repeat (4) cycle(0, z, 1, 0);
        // backpressure drop
        for (int i = 0; i < 6; i++) cycle(1, mk(200 + i, 300 + i), 0, 0);
        repeat (3) cycle(0, z, 0, 0);
        check("bp_overflow", overflow, 1'b1);
        repeat (6) cycle(0, z, 1, 0);
        cycle(0, z, 0, 1);
        cycle(0, z, 0, 0);
        // full with simultaneous pop and push
        for (int i = 0; i < 5; i++) cycle(1, mk(400 + i, 500 + i), 0, 0);
        cycle(0, z, 1, 0);
        repeat (6) cycle(0, z, 1, 0);
        check("fullpop_overflow", overflow, 1'b0);
        // framing and ReLU
        cycle(0, z, 0, 1);
        tile_rows = 8'd2;
        relu_en = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1, mk(-3, i), 1, 0);
        repeat (3) cycle(0, z, 1, 0);
        relu_en = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1, mk(-3, 10 + i), 1, 0);
        repeat (3) cycle(0, z, 1, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) tile_rows = RW'($urandom_range(0, 4));
            relu_en = $urandom_range(0, 1) == 1;
            cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 60) == 0);
        end
        repeat (6) cycle(0, z, 1, 0);
        // async reset with two rows queued and one half-skewed
        relu_en = 1'b0;
        cycle(1, mk(31, 41), 0, 0);
        cycle(1, mk(32, 42), 0, 0);
        cycle(1, mk(33, 43), 0, 0);
        do_reset();
        tile_rows = 8'd0;
        cycle(1, mk(11, 22), 0, 0);
        cycle(0, z, 0, 0);
        check("post_rst_data", out_data, mk(11, 22));
        check("post_rst_last", out_last, 1'b1);
        cycle(0, z, 1, 0);
        repeat (3) cycle(0, z, 1, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
